// File: rtl/sobel_window.sv
// sobel_window: turns a raster pixel stream into 3x3 neighbourhoods for a Sobel stage.
// Two line buffers hold the previous two lines. A 3x3 shift register forms the window.
// Only windows whose centre is an interior pixel are flagged valid.
module sobel_window #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 9
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                sof,
    input  logic                pix_valid,
    input  logic [7:0]          pix_in,
    output logic                pix_ready,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [7:0]          pixel0,
    output logic [7:0]          pixel1,
    output logic [7:0]          pixel2,
    output logic [7:0]          pixel3,
    output logic [7:0]          pixel4,
    output logic [7:0]          pixel5,
    output logic [7:0]          pixel6,
    output logic [7:0]          pixel7,
    output logic [7:0]          pixel8,
    output logic [COL_BITS-1:0] win_col,
    output logic [ROW_BITS-1:0] win_row,
    output logic                frame_done
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] cur_col;
    logic [ROW_BITS-1:0] cur_row;
    logic                accept;
    logic                centre_ok;
    logic [7:0]          top;
    logic [7:0]          mid;

    // Two previous lines; never reset, every entry is rewritten before it reaches a valid window.
    logic [7:0] line_a [IMG_WIDTH];
    logic [7:0] line_b [IMG_WIDTH];

    // A pending window blocks the input until downstream takes it, so the window never changes under a stall.
    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    // sof forces the accepted pixel to (0,0) whatever the counters hold.
    assign cur_col   = sof ? '0 : col;
    assign cur_row   = sof ? '0 : row;
    assign top       = line_a[cur_col];
    assign mid       = line_b[cur_col];
    assign centre_ok = (cur_row >= ROW_BITS'(2)) && (cur_col >= COL_BITS'(2));

    // Roll the column of the line buffers down by one line on each accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            line_a[cur_col] <= line_b[cur_col];
            line_b[cur_col] <= pix_in;
        end
    end

    // Raster position of the next pixel, with line and frame wrap; frame_done marks the last pixel.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
            if (accept) begin
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    row <= (cur_row == LAST_ROW) ? '0 : cur_row + ROW_BITS'(1);
                end else begin
                    col <= cur_col + COL_BITS'(1);
                    row <= cur_row;
                end
            end
        end
    end

    // Shift the 3x3 window left on accept; flag it valid once the centre is an interior pixel.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            pixel0    <= '0;
            pixel1    <= '0;
            pixel2    <= '0;
            pixel3    <= '0;
            pixel4    <= '0;
            pixel5    <= '0;
            pixel6    <= '0;
            pixel7    <= '0;
            pixel8    <= '0;
        end else if (accept) begin
            pixel0    <= pixel1;
            pixel1    <= pixel2;
            pixel2    <= top;
            pixel3    <= pixel4;
            pixel4    <= pixel5;
            pixel5    <= mid;
            pixel6    <= pixel7;
            pixel7    <= pixel8;
            pixel8    <= pix_in;
            win_valid <= centre_ok;
            if (centre_ok) begin
                win_col <= cur_col - COL_BITS'(1);
                win_row <= cur_row - ROW_BITS'(1);
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window on a 4x3 image whose pixel value is 10*row+col.
module tb_sobel_window;

    logic       clock;
    logic       nReset;
    logic       sof;
    logic       pix_valid;
    logic [7:0] pix_in;
    logic       pix_ready;
    logic       win_valid;
    logic       win_ready;
    logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8;
    logic [1:0] win_col;
    logic [1:0] win_row;
    logic       frame_done;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [71:0] px;
        logic [1:0]  col;
        logic [1:0]  row;
    } win_t;

    win_t wins[$];
    int   fd_count = 0;

    sobel_window #(
        .IMG_WIDTH (4),
        .IMG_HEIGHT(3),
        .COL_BITS  (2),
        .ROW_BITS  (2)
    ) dut (
        .clock     (clock),
        .nReset    (nReset),
        .sof       (sof),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_ready (pix_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .pixel0    (pixel0),
        .pixel1    (pixel1),
        .pixel2    (pixel2),
        .pixel3    (pixel3),
        .pixel4    (pixel4),
        .pixel5    (pixel5),
        .pixel6    (pixel6),
        .pixel7    (pixel7),
        .pixel8    (pixel8),
        .win_col   (win_col),
        .win_row   (win_row),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required run to complete");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [71:0] cur_px();
        return {pixel8, pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0};
    endfunction

    // Window whose centre column is k+1 on row 1 of the 10*row+col image.
    function automatic logic [71:0] exp_px(int k);
        logic [71:0] e;
        e = '0;
        for (int i = 0; i < 9; i++) e[i*8 +: 8] = 8'(10 * (i / 3) + k + (i % 3));
        return e;
    endfunction

    // Record every handshaken window and every frame_done pulse.
    always @(negedge clock) begin
        if (nReset && win_valid && win_ready) wins.push_back({cur_px(), win_col, win_row});
        if (nReset && frame_done) fd_count++;
    end

    task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one pixel and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(int r, int c, bit s);
        int n;
        pix_in    = 8'(10 * r + c);
        sof       = s;
        pix_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!pix_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (n >= 50) check("send_timeout", 72'(pix_ready), 72'(1));
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_frame(bit first_sof, bit gaps);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                send(r, c, first_sof && r == 0 && c == 0);
                if (gaps) idle(int'($urandom_range(0, 3)));
            end
        idle(3);
    endtask

    // Compare windows and frame_done pulses collected since the given marks with the reference frame.
    task automatic check_frame(string tag, int wbase, int fbase);
        check($sformatf("%s_count", tag), 72'(wins.size() - wbase), 72'(2));
        for (int k = 0; k < 2; k++) begin
            if (wbase + k < wins.size()) begin
                check($sformatf("%s_w%0d_px", tag, k), wins[wbase+k].px, exp_px(k));
                check($sformatf("%s_w%0d_col", tag, k), 72'(wins[wbase+k].col), 72'(k + 1));
                check($sformatf("%s_w%0d_row", tag, k), 72'(wins[wbase+k].row), 72'(1));
            end
        end
        check($sformatf("%s_frame_done", tag), 72'(fd_count - fbase), 72'(1));
    endtask

    initial begin
        int wb;
        int fb;
        logic [71:0] held;

        nReset    = 1'b0;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            sof       = 1'($urandom);
            pix_valid = 1'($urandom);
            pix_in    = 8'($urandom);
            win_ready = 1'($urandom);
            @(negedge clock);
            check("rst_win_valid", 72'(win_valid), 72'(0));
            check("rst_frame_done", 72'(frame_done), 72'(0));
            check("rst_pixels", cur_px(), 72'(0));
            check("rst_pix_ready", 72'(pix_ready), 72'(1));
            check("rst_win_pos", 72'({win_row, win_col}), 72'(0));
        end
        @(posedge clock);
        #1;
        sof       = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b1;
        nReset    = 1'b1;
        idle(2);

        // Full frame with latency checks
        wb = wins.size();
        fb = fd_count;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                send(r, c, r == 0 && c == 0);
                if (r == 2 && c == 2) begin
                    check("lat_valid", 72'(win_valid), 72'(1));
                    check("lat_px", cur_px(), exp_px(0));
                    check("lat_pos", 72'({win_row, win_col}), 72'({2'd1, 2'd1}));
                end else if (r == 2 && c == 3) begin
                    check("last_valid", 72'(win_valid), 72'(1));
                    check("last_col", 72'(win_col), 72'(2));
                    check("fd_pulse", 72'(frame_done), 72'(1));
                end else if (r == 1 && c == 3) begin
                    check("border_no_win", 72'(win_valid), 72'(0));
                end
            end
        idle(1);
        check("fd_single", 72'(frame_done), 72'(0));
        check("win_cleared", 72'(win_valid), 72'(0));
        idle(2);
        check_frame("full", wb, fb);

        // Backpressure on the first window
        wb = wins.size();
        fb = fd_count;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (!(r == 2 && c == 3)) send(r, c, r == 0 && c == 0);
        held      = cur_px();
        win_ready = 1'b0;
        pix_in    = 8'd23;
        pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_pix_ready", 72'(pix_ready), 72'(0));
            check("bp_hold_px", cur_px(), held);
        end
        check("bp_hold_valid", 72'(win_valid), 72'(1));
        check("bp_hold_pos", 72'({win_row, win_col}), 72'({2'd1, 2'd1}));
        @(posedge clock);
        #1;
        win_ready = 1'b1;
        send(2, 3, 1'b0);
        idle(3);
        check_frame("backpressure", wb, fb);

        // Frame without sof relies on wrap, with random idle gaps
        wb = wins.size();
        fb = fd_count;
        send_frame(1'b0, 1'b1);
        check_frame("gaps", wb, fb);

        // sof arriving at position (1,2) restarts the frame
        wb = wins.size();
        fb = fd_count;
        for (int i = 0; i < 6; i++) send(i / 4, i % 4, i == 0);
        check("sof_partial_no_win", 72'(wins.size() - wb), 72'(0));
        send_frame(1'b1, 1'b0);
        check_frame("mid_sof", wb, fb);

        // Reset pulse after 7 accepts, then a frame without sof
        wb = wins.size();
        fb = fd_count;
        for (int i = 0; i < 7; i++) send(i / 4, i % 4, i == 0);
        nReset = 1'b0;
        @(negedge clock);
        check("rst2_win_valid", 72'(win_valid), 72'(0));
        check("rst2_pixels", cur_px(), 72'(0));
        idle(2);
        nReset = 1'b1;
        idle(1);
        send_frame(1'b0, 1'b0);
        check_frame("after_reset", wb, fb);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-003 The block SHALL have parameter COL_BITS, default 10, meaning column counter width.
REQ-004 The block SHALL have parameter ROW_BITS, default 9, meaning row counter width.
REQ-005 The block SHALL have port clock  in  1  rising-edge system clock.
REQ-006 The block SHALL have port nReset  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port sof  in  1  start of frame; qualifies the pixel on pix_in.
REQ-008 The block SHALL have port pix_valid  in  1  input pixel valid.
REQ-009 The block SHALL have port pix_in  in  8  grayscale pixel, raster order.
REQ-010 The block SHALL have port pix_ready  out  1  block accepts pix_in this cycle.
REQ-011 The block SHALL have port win_valid  out  1  3x3 window valid.
REQ-012 The block SHALL have port win_ready  in  1  downstream Sobel stage consumes the window.
REQ-013 The block SHALL have ports pixel0..pixel8  out  8 each  window, row-major; pixel0 = top-left, pixel4 = centre, pixel8 = bottom-right.
REQ-014 The block SHALL have port win_col  out  COL_BITS  centre column of the window.
REQ-015 The block SHALL have port win_row  out  ROW_BITS  centre row of the window.
REQ-016 The block SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-017 Accept SHALL occur when pix_valid and pix_ready are both 1.
REQ-018 pix_ready SHALL equal (!win_valid || win_ready), combinationally.
REQ-019 The block SHALL keep counters col and row for the next pixel to be accepted.
REQ-020 An accept with sof=1 SHALL be treated as pixel (0,0), regardless of the counter values.
REQ-021 On accept at column c, the block SHALL do the following:
- top = lineA[c], mid = lineB[c], bot = pix_in;
- lineA[c] <= lineB[c], lineB[c] <= pix_in.
REQ-022 Line buffers SHALL be two IMG_WIDTH x 8 arrays with same-cycle read and write-on-accept.
REQ-023 On accept, the window SHALL shift left. Each row becomes (old col1, old col2, new):
- pixel0<=pixel1, pixel1<=pixel2, pixel2<=top;
- pixel3<=pixel4, pixel4<=pixel5, pixel5<=mid;
- pixel6<=pixel7, pixel7<=pixel8, pixel8<=bot.
REQ-024 When the accepted pixel has row>=2 and col>=2, the block SHALL do the following on the next edge:
- set win_valid=1;
- set win_row=row-1 and win_col=col-1.
REQ-025 An accept outside REQ-024 SHALL clear win_valid on the next edge.
REQ-026 With no accept, win_valid SHALL clear when win_ready=1, else hold.
REQ-027 Window outputs, win_row and win_col SHALL stay stable while win_valid=1 and win_ready=0.
REQ-028 Latency SHALL be one cycle: win_valid rises on the edge after the accept that completes the window.
REQ-029 Column wrap: an accept at col=IMG_WIDTH-1 SHALL set col=0 and row=row+1.
REQ-030 Frame wrap: an accept at (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL set row=0 and col=0, and pulse frame_done for one cycle on the next edge.
REQ-031 Border pixels (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) SHALL never appear as a window centre.
REQ-032 A frame SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
REQ-033 pix_valid=0 gaps SHALL NOT change the window sequence.
REQ-034 A mid-frame sof SHALL restart counting from (0,0) with no flush. A window already pending SHALL still be delivered.

Reset
REQ-035 While nReset=0, the following outputs SHALL be 0: win_valid, frame_done, pixel0..8, win_row, win_col.
REQ-036 While nReset=0, col and row SHALL be 0 and pix_ready SHALL be 1.
REQ-037 Line buffer contents SHALL NOT be reset; they are overwritten before they are used.
REQ-038 Deassertion of nReset SHALL take effect at the next rising clock edge.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3; pixel value = 10*row+col)
REQ-039 Reset: hold nReset=0 with random inputs -> win_valid=0, frame_done=0, all pixels 0, pix_ready=1.
REQ-040 Full frame, sof on the first pixel, win_ready=1 -> exactly two windows, then frame_done pulses once, on the edge after accepting (2,3):
- first window, on the edge after accepting (2,2): 0,1,2,10,11,12,20,21,22, with win_row=1, win_col=1;
- second window: 1,2,3,11,12,13,21,22,23, with win_col=2.
REQ-041 Backpressure: win_ready=0 for 5 cycles while win_valid=1 -> pix_ready=0, no accept, outputs unchanged; then win_ready=1 -> sequence continues identical to REQ-040.
REQ-042 Gaps: random pix_valid idles across the frame -> window sequence identical to REQ-040.
REQ-043 sof at (1,2), followed by a full frame -> no window before the new (2,2); windows then match REQ-040.
REQ-044 nReset pulse after 7 accepts, then a full frame -> no window from the partial frame; windows then match REQ-040.
